button_pulse_conditioner: RTL and testbench

//  Front end for the four password push buttons. Turns raw, asynchronous, bouncing

---
 rtl/button_pulse_conditioner.sv | 143 ++++++++++++++
 tb/tb_button_pulse_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
// Four-button front end: two-FF sync, per-button debounce, press-edge detect and a
// one-key-at-a-time gate. Define BTN_ACTIVE_LOW_EN for buttons that pull low when pressed.
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic       pulse_b1,
  output logic       pulse_b2,
  output logic       pulse_b3,
  output logic       pulse_b4,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       multi_press,
  output logic       any_held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HELD
  } state_t;

  logic [3:0]       w_btn;
  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_stable;
  logic [3:0]       w_stable_nxt;
  logic [3:0]       w_press;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt_nxt [4];
  logic             w_single;
  logic             w_multi;
  logic [1:0]       w_idx;
  state_t           r_state;
  logic [3:0]       r_pulse;
  logic             r_key_valid;
  logic [1:0]       r_key_code;
  logic             r_multi;
  logic             r_any_held;

`ifdef BTN_ACTIVE_LOW_EN
  assign w_btn = ~btn_raw;
`else
  assign w_btn = btn_raw;
`endif

  // Stage: two-flop synchroniser; reset value means "released"
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 4'd0;
      r_s2 <= 4'd0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_s2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_stable_nxt[i] = r_s2[i];
        w_cnt_nxt[i]    = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_press  = w_stable_nxt & ~r_stable;
  assign w_single = (w_press != 4'd0) && ((w_press & (w_press - 4'd1)) == 4'd0);
  assign w_multi  = (w_press != 4'd0) && !w_single;

  always_comb begin
    w_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_press[i]) w_idx = 2'(i);
    end
  end

  // Stage: debounce state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      r_stable   <= 4'd0;
      r_any_held <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_stable   <= w_stable_nxt;
      r_any_held <= |w_stable_nxt;
    end
  end

  // Stage: key FSM; HELD waits for every debounced level to drop before re-arming
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pulse     <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 2'd0;
      r_multi     <= 1'b0;
    end else begin
      r_pulse     <= 4'd0;
      r_key_valid <= 1'b0;
      r_multi     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            r_pulse     <= w_press;
            r_key_valid <= 1'b1;
            r_key_code  <= w_idx;
            r_state     <= S_HELD;
          end else if (w_multi) begin
            r_multi <= 1'b1;
            r_state <= S_HELD;
          end
        end
        S_HELD: begin
          if (r_stable == 4'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pulse_b1    = r_pulse[0];
  assign pulse_b2    = r_pulse[1];
  assign pulse_b3    = r_pulse[2];
  assign pulse_b4    = r_pulse[3];
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign multi_press = r_multi;
  assign any_held    = r_any_held;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner with a window-based debounce reference model;
// stimulus is given as logical press levels and mapped to the board polarity.
module tb_button_pulse_conditioner;

  localparam int D  = 4;
  localparam int CW = 3;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic [3:0] IDLE = 4'hF;
`else
  localparam logic [3:0] IDLE = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = IDLE;
  logic       pulse_b1, pulse_b2, pulse_b3, pulse_b4;
  logic       key_valid, multi_press, any_held;
  logic [1:0] key_code;

  int checks = 0;
  int errors = 0;

  button_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .pulse_b1(pulse_b1), .pulse_b2(pulse_b2), .pulse_b3(pulse_b3), .pulse_b4(pulse_b4),
    .key_valid(key_valid), .key_code(key_code), .multi_press(multi_press), .any_held(any_held)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronised input (two edges late)
  // has disagreed with the accepted level for D consecutive edges.
  logic [3:0] hist [0:7];
  logic [3:0] m_stable, m_new, m_prs, m_pulse;
  logic       m_held, m_kv, m_multi, m_any, all_diff;
  logic [1:0] m_code;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 8; j++) hist[j] = 4'd0;
      m_stable = 4'd0; m_held = 1'b0; m_pulse = 4'd0; m_kv = 1'b0;
      m_code = 2'd0; m_multi = 1'b0; m_any = 1'b0;
    end else begin
      m_new = m_stable;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) m_new[i] = ~m_stable[i];
      end
      m_prs = m_new & ~m_stable;
      m_pulse = 4'd0; m_kv = 1'b0; m_multi = 1'b0;
      if (!m_held) begin
        if ($countones(m_prs) == 1) begin
          m_pulse = m_prs; m_kv = 1'b1; m_held = 1'b1;
          for (int i = 0; i < 4; i++) if (m_prs[i]) m_code = 2'(i);
        end else if ($countones(m_prs) > 1) begin
          m_multi = 1'b1; m_held = 1'b1;
        end
      end else if (m_stable == 4'd0) begin
        m_held = 1'b0;
      end
      m_stable = m_new;
      m_any = |m_new;
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_raw ^ IDLE;
    end
  end

  wire [8:0] dut_vec = {pulse_b4, pulse_b3, pulse_b2, pulse_b1, key_valid, key_code, multi_press, any_held};
  wire [8:0] exp_vec = {m_pulse, m_kv, m_code, m_multi, m_any};

  task automatic do_reset();
    reset = 1'b1;
    btn_raw = IDLE;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      btn_raw = 4'($urandom);
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== 9'd0) begin
        errors++; $display("FAIL reset c=%0d got=%b exp=%b", c, dut_vec, 9'd0);
      end
    end
    btn_raw = IDLE;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_press();
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      btn_raw = ((c <= 20) ? 4'b0001 : 4'b0000) ^ IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || pulse_b1 !== (c == 6) || key_valid !== (c == 6) ||
          key_code !== 2'd0 || any_held !== (c >= 6 && c <= 25)) begin
        errors++; $display("FAIL single_press c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      btn_raw = ((c <= 12 && ((c - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000) ^ IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || dut_vec !== 9'd0) begin
        errors++; $display("FAIL bounce c=%0d got=%b exp=%b", c, dut_vec, 9'd0);
      end
    end
  endtask

  task automatic test_multi_press();
    logic [3:0] lvl;
    do_reset();
    for (int c = 1; c <= 34; c++) begin
      lvl = (c <= 12) ? 4'b0011 : ((c >= 23) ? 4'b1000 : 4'b0000);
      btn_raw = lvl ^ IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || multi_press !== (c == 6) || pulse_b1 !== 1'b0 ||
          pulse_b2 !== 1'b0 || pulse_b4 !== (c == 28) || key_valid !== (c == 28)) begin
        errors++; $display("FAIL multi_press c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
    checks++;
    if (key_code !== 2'd3) begin
      errors++; $display("FAIL multi_then_single key_code got=%0d exp=3", key_code);
    end
  endtask

  task automatic test_held_ignore();
    logic [3:0] lvl;
    do_reset();
    for (int c = 1; c <= 52; c++) begin
      if (c <= 10 || (c >= 21 && c <= 30)) lvl = 4'b0001;
      else if (c <= 20) lvl = 4'b0011;
      else if (c <= 40) lvl = 4'b0000;
      else lvl = 4'b0100;
      btn_raw = lvl ^ IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || pulse_b1 !== (c == 6) || pulse_b2 !== 1'b0 ||
          pulse_b3 !== (c == 46) || (c >= 46 && key_code !== 2'd2)) begin
        errors++; $display("FAIL held_ignore c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      btn_raw = 4'b0001 ^ IDLE;
      reset = (c == 4);
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || pulse_b1 !== (c == 10)) begin
        errors++; $display("FAIL reset_mid c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_polarity();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      btn_raw = IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== 9'd0) begin
        errors++; $display("FAIL idle_level c=%0d got=%b exp=%b", c, dut_vec, 9'd0);
      end
    end
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      btn_raw = ((c <= 12) ? 4'b0100 : 4'b0000) ^ IDLE;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec || pulse_b3 !== (c == 6) || (c >= 6 && key_code !== 2'd2)) begin
        errors++; $display("FAIL polarity c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    int hold;
    do_reset();
    lvl = 4'd0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: lvl = 4'd0;
          1: lvl = 4'b0001 << $urandom_range(0, 3);
          2: lvl = lvl ^ (4'b0001 << $urandom_range(0, 3));
          default: lvl = 4'($urandom);
        endcase
        hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      hold--;
      btn_raw = lvl ^ IDLE;
      reset = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_press();
    test_held_ignore();
    test_reset_mid_debounce();
    test_polarity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
